// File: rtl/reg_file_rename_pkg.sv
// Shared widths for the architectural register file and its read ports.
// The ROB id width stays a module parameter so it tracks the ROB configuration.
package reg_file_rename_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
endpackage

// File: rtl/rf_read_port.sv
// One decoder source-operand port: selected register state plus the
// same-cycle commit bypass for a register whose producer is committing now.
module rf_read_port
  import reg_file_rename_pkg::*;
#(
  parameter int ROB_SIZE_BIT = 5
) (
  input  logic [REG_IDX_W-1:0]    qry_id,
  input  logic                    sel_busy,
  input  logic [ROB_SIZE_BIT-1:0] sel_dep,
  input  logic [DATA_W-1:0]       sel_val,
  input  logic                    commit_en,
  input  logic [REG_IDX_W-1:0]    commit_id,
  input  logic [ROB_SIZE_BIT-1:0] commit_dep,
  input  logic [DATA_W-1:0]       commit_val,
  output logic                    has_dep,
  output logic [ROB_SIZE_BIT-1:0] dep,
  output logic [DATA_W-1:0]       val
);

  logic commit_hit;

  // Only the commit of the register's current producer resolves the wait.
  assign commit_hit = commit_en && (commit_id != '0) && (qry_id == commit_id)
                      && sel_busy && (sel_dep == commit_dep);

  always_comb begin
    has_dep = sel_busy;
    dep     = sel_dep;
    val     = sel_val;
    if (qry_id == '0) begin
      has_dep = 1'b0;
      val     = '0;
    end else if (commit_hit) begin
      has_dep = 1'b0;
      val     = commit_val;
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags (busy + ROB id).
// Commit writes values; issue installs a new producer; a ROB clear drops all tags.
module reg_file_rename
  import reg_file_rename_pkg::*;
#(
  parameter int ROB_SIZE_BIT = 5,
  parameter int NUM_REGS     = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [REG_IDX_W-1:0]    update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [DATA_W-1:0]       update_val,
  input  logic                    is_update_dep,
  input  logic [REG_IDX_W-1:0]    update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [REG_IDX_W-1:0]    qry1_id,
  output logic                    qry1_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  output logic [DATA_W-1:0]       qry1_val,
  input  logic [REG_IDX_W-1:0]    qry2_id,
  output logic                    qry2_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep,
  output logic [DATA_W-1:0]       qry2_val
);

  logic [DATA_W-1:0]       val_reg  [NUM_REGS];
  logic                    busy_reg [NUM_REGS];
  logic [ROB_SIZE_BIT-1:0] dep_reg  [NUM_REGS];

  logic commit_en;
  logic issue_en;

  // Same-cycle commits and issues during a clear are wrong-path and dropped.
  assign commit_en = is_update_val && !rob_clear;
  assign issue_en  = is_update_dep && !rob_clear;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_reg[i]  <= '0;
        busy_reg[i] <= 1'b0;
        dep_reg[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          busy_reg[i] <= 1'b0;
        end
      end
      if (commit_en && (update_val_id != '0)) begin
        val_reg[update_val_id] <= update_val;
        if (busy_reg[update_val_id] && (dep_reg[update_val_id] == update_val_dep)) begin
          busy_reg[update_val_id] <= 1'b0;
        end
      end
      // Placed after the commit so a same-register issue wins the busy bit.
      if (issue_en && (update_dep_id != '0)) begin
        busy_reg[update_dep_id] <= 1'b1;
        dep_reg[update_dep_id]  <= update_dep;
      end
    end
  end

  rf_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_port1 (
    .qry_id     (qry1_id),
    .sel_busy   (busy_reg[qry1_id]),
    .sel_dep    (dep_reg[qry1_id]),
    .sel_val    (val_reg[qry1_id]),
    .commit_en  (commit_en),
    .commit_id  (update_val_id),
    .commit_dep (update_val_dep),
    .commit_val (update_val),
    .has_dep    (qry1_has_dep),
    .dep        (qry1_dep),
    .val        (qry1_val)
  );

  rf_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_port2 (
    .qry_id     (qry2_id),
    .sel_busy   (busy_reg[qry2_id]),
    .sel_dep    (dep_reg[qry2_id]),
    .sel_val    (val_reg[qry2_id]),
    .commit_en  (commit_en),
    .commit_id  (update_val_id),
    .commit_dep (update_val_dep),
    .commit_val (update_val),
    .has_dep    (qry2_has_dep),
    .dep        (qry2_dep),
    .val        (qry2_val)
  );

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed scenarios then random traffic, all
// compared against a behavioural register/tag model kept in plain arrays.
module tb_reg_file_rename;
  localparam int RB = 5;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rob_clear;
  logic          is_update_val, is_update_dep;
  logic [4:0]    update_val_id, update_dep_id, qry1_id, qry2_id;
  logic [RB-1:0] update_val_dep, update_dep, qry1_dep, qry2_dep;
  logic [31:0]   update_val, qry1_val, qry2_val;
  logic          qry1_has_dep, qry2_has_dep;

  always #5 clk_in = ~clk_in;

  reg_file_rename #(.ROB_SIZE_BIT(RB), .NUM_REGS(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_update_val(is_update_val), .update_val_id(update_val_id),
    .update_val_dep(update_val_dep), .update_val(update_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .qry1_id(qry1_id), .qry1_has_dep(qry1_has_dep), .qry1_dep(qry1_dep), .qry1_val(qry1_val),
    .qry2_id(qry2_id), .qry2_has_dep(qry2_has_dep), .qry2_dep(qry2_dep), .qry2_val(qry2_val)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: committed value, whether a producer is outstanding, its tag.
  logic [31:0]   m_val  [32];
  bit            m_busy [32];
  logic [RB-1:0] m_dep  [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_port(input string p, input logic [4:0] id, input logic hd,
                            input logic [RB-1:0] d, input logic [31:0] v);
    logic          e_hd;
    logic [RB-1:0] e_d;
    logic [31:0]   e_v;
    e_hd = m_busy[id];
    e_d  = m_dep[id];
    e_v  = m_val[id];
    if (id == 5'd0) begin
      e_hd = 1'b0;
      e_v  = 32'd0;
    end else if (is_update_val && !rob_clear && id == update_val_id &&
                 m_busy[id] && m_dep[id] == update_val_dep) begin
      e_hd = 1'b0;
      e_v  = update_val;
    end
    check({p, "_has_dep"}, 64'(hd), 64'(e_hd));
    check({p, "_dep"}, 64'(d), 64'(e_d));
    check({p, "_val"}, 64'(v), 64'(e_v));
  endtask

  task automatic model_update();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_dep[i] = '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (is_update_val && update_val_id != 5'd0) begin
          m_val[update_val_id] = update_val;
          if (m_busy[update_val_id] && m_dep[update_val_id] == update_val_dep)
            m_busy[update_val_id] = 1'b0;
        end
        if (is_update_dep && update_dep_id != 5'd0) begin
          m_busy[update_dep_id] = 1'b1;
          m_dep[update_dep_id]  = update_dep;
        end
      end
    end
  endtask

  // One transaction: check both ports on the settled inputs, clock, update model.
  task automatic tick();
    #1;
    check_port("q1", qry1_id, qry1_has_dep, qry1_dep, qry1_val);
    check_port("q2", qry2_id, qry2_has_dep, qry2_dep, qry2_val);
    $display("t=%0t rst=%b rdy=%b clr=%b cv=%b x%0d t%0d %h iss=%b x%0d t%0d | q1 x%0d %b %0d %h | q2 x%0d %b %0d %h",
             $time, rst_in, rdy_in, rob_clear, is_update_val, update_val_id, update_val_dep,
             update_val, is_update_dep, update_dep_id, update_dep, qry1_id, qry1_has_dep,
             qry1_dep, qry1_val, qry2_id, qry2_has_dep, qry2_dep, qry2_val);
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    is_update_val = 1'b0; update_val_id = '0; update_val_dep = '0; update_val = '0;
    is_update_dep = 1'b0; update_dep_id = '0; update_dep = '0;
  endtask

  task automatic issue(input logic [4:0] id, input logic [RB-1:0] tag);
    idle();
    is_update_dep = 1'b1; update_dep_id = id; update_dep = tag;
  endtask

  task automatic commit(input logic [4:0] id, input logic [RB-1:0] tag, input logic [31:0] v);
    is_update_val = 1'b1; update_val_id = id; update_val_dep = tag; update_val = v;
  endtask

  initial begin
    idle();
    qry1_id = 5'd5; qry2_id = 5'd0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_dep[i] = '0;
    end
    @(negedge clk_in);
    idle();
    #1;
    check("reset_x5_has_dep", 64'(qry1_has_dep), 64'd0);
    check("reset_x5_val", 64'(qry1_val), 64'd0);

    // x0 ignores commits
    commit(5'd0, 5'd0, 32'hDEADBEEF);
    tick();
    idle(); qry2_id = 5'd0;
    #1 check("x0_after_write", 64'(qry2_val), 64'd0);
    tick();

    // Issue, then same-cycle commit bypass
    issue(5'd3, 5'd7); tick();
    idle(); qry1_id = 5'd3;
    #1 check("x3_busy", 64'(qry1_has_dep), 64'd1);
    check("x3_tag", 64'(qry1_dep), 64'd7);
    tick();
    commit(5'd3, 5'd7, 32'h1234);
    #1 check("x3_bypass_has_dep", 64'(qry1_has_dep), 64'd0);
    check("x3_bypass_val", 64'(qry1_val), 64'h1234);
    tick();
    idle();
    #1 check("x3_cleared", 64'(qry1_has_dep), 64'd0);
    tick();

    // Older commit leaves a younger producer's tag in place
    issue(5'd4, 5'd2); tick();
    issue(5'd4, 5'd3); tick();
    idle(); commit(5'd4, 5'd2, 32'h55); qry1_id = 5'd4; tick();
    idle();
    #1 check("x4_still_busy", 64'(qry1_has_dep), 64'd1);
    check("x4_tag", 64'(qry1_dep), 64'd3);
    check("x4_val", 64'(qry1_val), 64'h55);
    tick();

    // Commit and issue to the same register in one cycle
    issue(5'd6, 5'd1); tick();
    issue(5'd6, 5'd4); commit(5'd6, 5'd1, 32'd9); qry1_id = 5'd6;
    #1 check("x6_same_cycle_has_dep", 64'(qry1_has_dep), 64'd0);
    check("x6_same_cycle_val", 64'(qry1_val), 64'd9);
    tick();
    idle();
    #1 check("x6_next_has_dep", 64'(qry1_has_dep), 64'd1);
    check("x6_next_tag", 64'(qry1_dep), 64'd4);
    check("x6_next_val", 64'(qry1_val), 64'd9);
    tick();

    // ROB clear drops all tags and the simultaneous commit
    issue(5'd1, 5'd1); tick();
    issue(5'd2, 5'd2); tick();
    issue(5'd9, 5'd3); tick();
    idle(); rob_clear = 1'b1; commit(5'd9, 5'd3, 32'hAA); qry1_id = 5'd9; qry2_id = 5'd1;
    tick();
    idle(); qry2_id = 5'd2;
    #1 check("x9_val_kept", 64'(qry1_val), 64'd0);
    check("x9_has_dep", 64'(qry1_has_dep), 64'd0);
    check("x2_has_dep", 64'(qry2_has_dep), 64'd0);
    tick();

    // rdy_in low holds state
    issue(5'd7, 5'd5); rdy_in = 1'b0; qry1_id = 5'd7; tick();
    idle();
    #1 check("x7_held", 64'(qry1_has_dep), 64'd0);
    tick();
    issue(5'd7, 5'd5); tick();
    idle();
    #1 check("x7_busy", 64'(qry1_has_dep), 64'd1);
    check("x7_tag", 64'(qry1_dep), 64'd5);
    tick();
    rst_in = 1'b1; tick();
    idle(); qry2_id = 5'd4;
    #1 check("rst_x7", 64'(qry1_has_dep), 64'd0);
    check("rst_x4_val", 64'(qry2_val), 64'd0);
    tick();

    // Random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] cid;
      rdy_in    = ($urandom_range(0, 9) != 0);
      rst_in    = ($urandom_range(0, 199) == 0);
      rob_clear = ($urandom_range(0, 19) == 0);
      cid = 5'($urandom_range(0, 7));
      is_update_val  = 1'($urandom_range(0, 1));
      update_val_id  = cid;
      update_val_dep = ($urandom_range(0, 1) != 0) ? m_dep[cid] : RB'($urandom);
      update_val     = $urandom;
      is_update_dep  = 1'($urandom_range(0, 1));
      update_dep_id  = 5'($urandom_range(0, 7));
      update_dep     = RB'($urandom);
      qry1_id = ($urandom_range(0, 2) == 0) ? cid : 5'($urandom_range(0, 7));
      qry2_id = 5'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
